// File: rtl/repeated_sub_divider.sv
// Unsigned divider: Q = A / B, R = A % B by repeated subtraction; a zero divisor raises invalid.
// Done is entered on edge 1+2q after the edge that accepts start; start is ignored while busy.
module repeated_sub_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             invalid,
    output logic             Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_SUB   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_br;
    logic             r_inv;
    logic             w_load;
    logic             w_sub;
    logic             w_set_inv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = S_IDLE;
        w_load    = 1'b0;
        w_sub     = 1'b0;
        w_set_inv = 1'b0;
        busy      = 1'b0;
        Done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = S_CHECK;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (r_br == '0) begin
                    w_set_inv = 1'b1;
                    w_next    = S_DONE;
                end else if (r_r >= r_br) begin
                    w_next = S_SUB;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_SUB: begin
                busy   = 1'b1;
                w_sub  = 1'b1;
                w_next = S_CHECK;
            end
            S_DONE: begin
                busy   = 1'b1;
                Done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // R doubles as the working dividend; subtraction never underflows since S_SUB requires R >= Br
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= '0;
            r_r   <= '0;
            r_br  <= '0;
            r_inv <= 1'b0;
        end else if (w_load) begin
            r_q   <= '0;
            r_r   <= A;
            r_br  <= B;
            r_inv <= 1'b0;
        end else if (w_sub) begin
            r_q <= r_q + 1'b1;
            r_r <= r_r - r_br;
        end else if (w_set_inv) begin
            r_inv <= 1'b1;
        end
    end

    assign Q       = r_q;
    assign R       = r_r;
    assign invalid = r_inv;

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Scoreboard bench for repeated_sub_divider: stimulus pushes expected quotient/remainder/flag and
// completion edge; a negedge monitor pops on every Done pulse and compares.
module tb_repeated_sub_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         busy;
    logic         invalid;
    logic         Done;

    typedef struct {
        int q;
        int r;
        int inv;
        int done_at;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_done   = 0;

    repeated_sub_divider #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .Q      (Q),
        .R      (R),
        .busy   (busy),
        .invalid(invalid),
        .Done   (Done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division; q subtract/check pairs follow the initial check.
    task automatic push_exp(input int a, input int b, input int e0);
        exp_t e;
        if (b == 0) begin
            e.q = 0; e.r = a; e.inv = 1; e.done_at = e0 + 1;
        end else begin
            e.q = a / b; e.r = a % b; e.inv = 0; e.done_at = e0 + 1 + 2 * (a / b);
        end
        sb.push_back(e);
        n_push++;
    endtask

    always @(negedge clk) begin
        if (rst && Done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("Q", int'(Q), e.q);
                chk("R", int'(R), e.r);
                chk("invalid", int'(invalid), e.inv);
                chk("done_edge", cyc, e.done_at);
                chk("busy_at_done", int'(busy), 1);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        chk("done_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_op(input int a, input int b, output int e0);
        wait_idle();
        A = W'(a); B = W'(b); start = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        push_exp(a, b, e0);
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom); B = W'($urandom);
        chk("busy_after_accept", int'(busy), 1);
        chk("inv_cleared", int'(invalid), 0);
        chk("q_cleared", int'(Q), 0);
    endtask

    initial begin
        int e0;
        int prev;
        #12;
        chk("rst_Q", int'(Q), 0);
        chk("rst_R", int'(R), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_inv", int'(invalid), 0);
        @(negedge clk); rst = 1'b1;

        do_op(17, 5, e0);  drain();
        do_op(5, 0, e0);   drain();
        do_op(9, 3, e0);   drain();
        do_op(3, 7, e0);   drain();
        do_op(0, 4, e0);   drain();
        do_op(12, 12, e0); drain();
        do_op(255, 1, e0); drain();

        // Second start while busy must neither restart nor change operands.
        do_op(20, 4, e0);
        while (cyc < e0 + 2) @(negedge clk);
        A = 8'd99; B = 8'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        drain();

        // Asynchronous reset in the middle of a clock period.
        do_op(100, 3, e0);
        repeat (8) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_Q", int'(Q), 0);
        chk("arst_R", int'(R), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(Done), 0);
        sb.delete();
        n_push--;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_op(100, 3, e0); drain();

        // start held high: back-to-back accepts spaced by one idle cycle.
        wait_idle();
        A = 8'd6; B = 8'd2; start = 1'b1;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            e0 = cyc;
            push_exp(6, 2, e0);
            if (k > 0) chk("held_period", e0 - prev, 9);
            prev = e0;
            wait_idle();
        end
        start = 1'b0;
        drain();

        for (int n = 0; n < 30; n++) begin
            int a;
            int b;
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            do_op(a, b, e0);
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();
        repeat (3) @(negedge clk);
        chk("done_count", n_done, n_push);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
